// File: rtl/sram_mixed_pkg.sv
// sram_mixed_pkg
// Shared definitions for the mixed-signal SRAM initiator:
//   state_t      - transaction FSM states
//   VDD_DEFAULT  - default logic-1 drive level (volts)
//   VTH_DEFAULT  - default sampling threshold (volts)
//   threshold()  - analog level -> bit (strictly above threshold reads 1)
//   drive()      - bit -> analog level (1 -> vdd, 0 -> 0.0)
package sram_mixed_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        PULSE   = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam real VDD_DEFAULT = 1.8;
    localparam real VTH_DEFAULT = 0.9;

    // A level sitting exactly on the threshold reads as 0.
    function automatic logic threshold(input real level, input real vth);
        return (level > vth);
    endfunction

    function automatic real drive(input logic bit_value, input real vdd);
        return bit_value ? vdd : 0.0;
    endfunction

endpackage

// File: rtl/sram_mixed_level_conv.sv
// sram_mixed_level_conv
// Per-bit level conversion between the digital initiator and the analog
// SRAM bus, in both directions.
// Ports:
//   clk_bit, we_bit        in   digital strobe / write enable
//   addr_bits, din_bits    in   digital address / write data
//   clk_level, we_level    out  analog strobe / write enable
//   addr_level, din_level  out  analog address / write data (one real per bit)
//   dout_level             in   analog read data (one real per bit)
//   dout_bits              out  thresholded read data
module sram_mixed_level_conv
    import sram_mixed_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  ADDR_WIDTH = 4,
    parameter real VDD        = VDD_DEFAULT,
    parameter real VTH        = VTH_DEFAULT
) (
    input  logic                  clk_bit,
    input  logic                  we_bit,
    input  logic [ADDR_WIDTH-1:0] addr_bits,
    input  logic [DATA_WIDTH-1:0] din_bits,
    output real                   clk_level,
    output real                   we_level,
    output real                   addr_level [ADDR_WIDTH],
    output real                   din_level  [DATA_WIDTH],
    input  real                   dout_level [DATA_WIDTH],
    output logic [DATA_WIDTH-1:0] dout_bits
);

    // Digital-to-analog: each bit becomes either the supply level or ground.
    always_comb begin
        clk_level = drive(clk_bit, VDD);
        we_level  = drive(we_bit, VDD);
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            addr_level[i] = drive(addr_bits[i], VDD);
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            din_level[i] = drive(din_bits[i], VDD);
        end
    end

    // Analog-to-digital: a plain comparator per data bit.
    always_comb begin
        dout_bits = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            dout_bits[i] = threshold(dout_level[i], VTH);
        end
    end

endmodule

// File: rtl/sram_mixed_initiator.sv
// sram_mixed_initiator
// Turns valid/ready read/write requests into a single clock pulse on an
// analog (real-valued) read-first SRAM bus and returns one response per
// request carrying the word the SRAM held before the access.
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_we, req_addr, req_wdata      request payload
//   rsp_valid/rsp_ready, rsp_rdata   response handshake and read data
//   sram_clk, sram_we                analog strobe and write enable
//   sram_addr, sram_din              analog address / write data, one real per bit
//   sram_dout                        analog read data from the SRAM
//   busy                             high whenever a transaction is in flight
module sram_mixed_initiator
    import sram_mixed_pkg::*;
#(
    parameter int  DATA_WIDTH      = 8,
    parameter int  ADDR_WIDTH      = 4,
    parameter real VDD             = VDD_DEFAULT,
    parameter real VTH             = VTH_DEFAULT,
    parameter int  CLK_HIGH_CYCLES = 2,
    parameter int  RD_WAIT_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output real                   sram_clk,
    output real                   sram_we,
    output real                   sram_addr [ADDR_WIDTH],
    output real                   sram_din  [DATA_WIDTH],
    input  real                   sram_dout [DATA_WIDTH],
    output logic                  busy
);

    // Both phases need at least one cycle; anything else is a bad build.
    generate
        if (CLK_HIGH_CYCLES < 1) begin : g_bad_high
            $error("sram_mixed_initiator: CLK_HIGH_CYCLES must be >= 1");
        end
        if (RD_WAIT_CYCLES < 1) begin : g_bad_wait
            $error("sram_mixed_initiator: RD_WAIT_CYCLES must be >= 1");
        end
    endgenerate

    localparam int PULSE_LAST = CLK_HIGH_CYCLES - 1;
    localparam int WAIT_LAST  = RD_WAIT_CYCLES - 1;
    localparam int CNT_MAX    = (PULSE_LAST > WAIT_LAST) ? PULSE_LAST : WAIT_LAST;
    localparam int CNT_W      = $clog2(CNT_MAX + 1) + 1;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  clk_bit;
    logic                  we_bit;
    logic [DATA_WIDTH-1:0] dout_bits;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs. PULSE and WAIT are timed by cnt,
    // which restarts from zero on every state change.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = PULSE;
            end
            PULSE: begin
                if (cnt == CNT_W'(PULSE_LAST)) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(WAIT_LAST)) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Phase counter for PULSE and WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state != next_state) begin
            cnt <= '0;
        end else if (state == PULSE || state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request payload is captured once at acceptance so later changes on
    // the request bus cannot disturb the access in flight. Clearing these
    // on reset is also what returns the analog address/data bus to 0.0.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Read data is sampled once, at the end of CAPTURE, and then held for
    // the whole RESP phase regardless of what the SRAM does afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata <= '0;
        end else if (state == CAPTURE) begin
            rsp_rdata <= dout_bits;
        end
    end

    // The strobe is high only in PULSE; write enable is held through the
    // whole access window so the SRAM sees a stable command around the rise.
    assign clk_bit = (state == PULSE);
    assign we_bit  = lat_we && ((state == SETUP) || (state == PULSE) || (state == WAIT));

    sram_mixed_level_conv #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .VDD        (VDD),
        .VTH        (VTH)
    ) u_level_conv (
        .clk_bit    (clk_bit),
        .we_bit     (we_bit),
        .addr_bits  (lat_addr),
        .din_bits   (lat_wdata),
        .clk_level  (sram_clk),
        .we_level   (sram_we),
        .addr_level (sram_addr),
        .din_level  (sram_din),
        .dout_level (sram_dout),
        .dout_bits  (dout_bits)
    );

endmodule

// File: tb/tb_sram_mixed_initiator.sv
// tb_sram_mixed_initiator
// Self-checking bench for sram_mixed_initiator at default parameters.
// A behavioural read-first SRAM sits on the analog pins; a separate
// word-level reference memory predicts every response.
module tb_sram_mixed_initiator;

    localparam real VDD_TB      = 1.8;
    localparam real VTH_TB      = 0.9;
    localparam int  HIGH_CYC    = 2;
    localparam int  WAIT_CYC    = 2;
    localparam int  EXP_LATENCY = 3 + HIGH_CYC + WAIT_CYC;
    localparam int  EXP_SPACING = EXP_LATENCY + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    real        sram_clk;
    real        sram_we;
    real        sram_addr [4];
    real        sram_din  [8];
    real        sram_dout [8] = '{default: 0.0};
    logic       busy;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    logic [7:0] sram_mem [16] = '{default: 8'h00};
    logic [7:0] ref_mem  [16];
    logic       sram_clk_prev = 1'b0;
    logic       force_dout    = 1'b0;

    sram_mixed_initiator #(
        .DATA_WIDTH      (8),
        .ADDR_WIDTH      (4),
        .VDD             (VDD_TB),
        .VTH             (VTH_TB),
        .CLK_HIGH_CYCLES (HIGH_CYC),
        .RD_WAIT_CYCLES  (WAIT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_clk  (sram_clk),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Read-first analog SRAM: on a rising strobe, present the old word on
    // dout, then write if enabled. The force mode parks bit 0 exactly on
    // the threshold and every other bit at the supply.
    always @(negedge clk) begin : sram_env
        logic       now_high;
        logic       we_now;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        now_high = (sram_clk > VTH_TB);
        if (now_high && !sram_clk_prev) begin
            for (int i = 0; i < 4; i++) a[i] = (sram_addr[i] > VTH_TB);
            for (int i = 0; i < 8; i++) d[i] = (sram_din[i] > VTH_TB);
            we_now = (sram_we > VTH_TB);
            rd = sram_mem[a];
            if (we_now) sram_mem[a] = d;
            for (int i = 0; i < 8; i++) begin
                if (force_dout) sram_dout[i] = (i == 0) ? 0.9 : VDD_TB;
                else            sram_dout[i] = rd[i] ? VDD_TB : 0.0;
            end
        end
        sram_clk_prev = now_high;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic drivesZero();
        logic z;
        z = (sram_clk == 0.0) && (sram_we == 0.0);
        for (int i = 0; i < 4; i++) z = z && (sram_addr[i] == 0.0);
        for (int i = 0; i < 8; i++) z = z && (sram_din[i] == 0.0);
        return z;
    endfunction

    function automatic logic [3:0] addrBits();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (sram_addr[i] == VDD_TB);
        return v;
    endfunction

    function automatic logic [7:0] dinBits();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = (sram_din[i] == VDD_TB);
        return v;
    endfunction

    // One complete transaction, entered and left just after a falling edge.
    // stall > 0 holds rsp_ready low for that many cycles once the response
    // appears, while a competing request is offered.
    task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_rdata, input int stall, output int rsp_cycle);
        bit got;
        int latency;
        int pulses;
        int hold_bad;
        rsp_cycle = -1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (stall == 0);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (req_ready) got = 1'b1;
            else @(negedge clk);
        end
        checkOutput("req_accept", 32'(got), 32'd1);
        if (!got) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 4'($urandom_range(0, 15));
        req_wdata = 8'($urandom_range(0, 255));
        got = 1'b0;
        latency = -1;
        pulses = 0;
        hold_bad = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                latency = k;
                rsp_cycle = cycle;
            end else begin
                if (sram_clk == VDD_TB) pulses++;
                if (k <= 1 + HIGH_CYC + WAIT_CYC) begin
                    if (sram_we != (we ? VDD_TB : 0.0)) hold_bad++;
                    if (addrBits() != addr) hold_bad++;
                    if (dinBits() != wdata) hold_bad++;
                end
                if (k == 1) begin
                    checkOutput("setup_clk_low", 32'(sram_clk == 0.0), 32'd1);
                    checkOutput("setup_busy", 32'(busy), 32'd1);
                    checkOutput("setup_req_ready", 32'(req_ready), 32'd0);
                end
            end
        end
        checkOutput("rsp_arrive", 32'(got), 32'd1);
        if (!got) return;
        checkOutput("latency", 32'(latency), 32'(EXP_LATENCY));
        checkOutput("pulse_cycles", 32'(pulses), 32'(HIGH_CYC));
        checkOutput("drive_hold", 32'(hold_bad), 32'd0);
        checkOutput("rsp_we_low", 32'(sram_we == 0.0), 32'd1);
        checkOutput("rdata", 32'(rsp_rdata), 32'(exp_rdata));
        if (stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = ~addr;
                @(negedge clk);
                checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
                checkOutput("stall_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
                checkOutput("stall_busy", 32'(busy), 32'd1);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
        checkOutput("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin : stimulus
        int         rc;
        int         prev_rc;
        int         seen;
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] e;

        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_drives", 32'(drivesZero()), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back, read-first on overwrite.
        $display("[TB] write/read addr 3");
        applyStimulus(1'b1, 4'd3, 8'hA5, ref_mem[3], 0, rc); ref_mem[3] = 8'hA5;
        applyStimulus(1'b0, 4'd3, 8'h00, ref_mem[3], 0, rc);
        applyStimulus(1'b1, 4'd3, 8'h3C, 8'hA5, 0, rc); ref_mem[3] = 8'h3C;
        applyStimulus(1'b0, 4'd3, 8'hFF, 8'h3C, 0, rc);

        // Response back-pressure.
        $display("[TB] rsp_ready stall");
        applyStimulus(1'b0, 4'd3, 8'h00, 8'h3C, 5, rc);

        // Bit 0 exactly on threshold.
        $display("[TB] threshold edge");
        force_dout = 1'b1;
        applyStimulus(1'b0, 4'd7, 8'h00, 8'hFE, 0, rc);
        force_dout = 1'b0;

        // Reset during PULSE: the strobe has already risen, so the write lands.
        $display("[TB] reset during pulse");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("pulse_before_reset", 32'(sram_clk == VDD_TB), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_drives", 32'(drivesZero()), 32'd1);
        checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        ref_mem[5] = 8'h5A;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput("no_rsp_after_reset", 32'(seen), 32'd0);
        applyStimulus(1'b0, 4'd5, 8'h00, ref_mem[5], 0, rc);

        // Back-to-back sweep over every address.
        $display("[TB] back-to-back sweep");
        prev_rc = 0;
        for (int i = 0; i < 16; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 4'(i);
            d  = 8'($urandom_range(0, 255));
            e  = ref_mem[a];
            applyStimulus(we, a, d, e, 0, rc);
            if (we) ref_mem[a] = d;
            if (i > 0) checkOutput("spacing", 32'(rc - prev_rc), 32'(EXP_SPACING));
            prev_rc = rc;
        end

        // Random traffic against the reference memory.
        $display("[TB] random traffic");
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            e  = ref_mem[a];
            applyStimulus(we, a, d, e, 0, rc);
            if (we) ref_mem[a] = d;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
